// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_t : clear-sweep controller state
//   DEF_N/DEF_R: default data width / address width
//   lane_win() : which write lane supplies the data for an address hit
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DEF_N = 32;
    localparam int DEF_R = 7;

    // hit0/hit1 say whether lane 0 / lane 1 writes the address in question.
    // Lane 1 is the younger retire lane, so it wins whenever it hits.
    function automatic logic lane_win(input logic hit0, input logic hit1);
        return (hit0 && !hit1) ? 1'b0 : hit1;
    endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear-sweep controller for reg_file_mp.
// After reset it walks every entry once, writing zero, then parks in RUN.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   o_clr_we      : 1 while sweeping; entry o_clr_addr is written with 0
//   o_clr_addr    : entry being cleared this cycle
//   o_ready       : 1 once the last entry has been cleared
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int R = DEF_R
) (
    input  logic         clk,
    input  logic         rst,
    output logic         o_clr_we,
    output logic [R-1:0] o_clr_addr,
    output logic         o_ready
);

    rf_state_t      r_state;
    logic [R:0]     r_ptr;
    logic           r_ready;
    logic [R:0]     w_ptr_next;

    // One spare bit so the terminal count shows up as a carry, no wrap.
    assign w_ptr_next = r_ptr + (R+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_ptr <= w_ptr_next;
                    // Carry out means this edge cleared the last entry.
                    if (w_ptr_next[R]) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr[R-1:0];
    assign o_ready    = r_ready;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write lanes, NR registered read ports with
// write-first bypass, optional hardwired-zero entry 0, and a clear sweep
// after reset that gates all accesses until ready.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ready        : 1 once the clear sweep is done
//   we/waddr/wdata : write lanes 0/1, packed lane k at [k*W +: W]
//   rd_en/rd_addr  : per-port read enable and packed address
//   rd_data      : packed registered read data, 1-cycle latency
//   wr_conflict  : pulse, both lanes wrote the same effective address
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int R        = DEF_R,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [1:0]      we,
    input  logic [2*R-1:0]  waddr,
    input  logic [2*N-1:0]  wdata,
    input  logic [NR-1:0]   rd_en,
    input  logic [NR*R-1:0] rd_addr,
    output logic [NR*N-1:0] rd_data,
    output logic            wr_conflict
);

    localparam int DEPTH = 1 << R;

    logic [N-1:0] r_mem [DEPTH];
    logic         r_wr_conflict;

    logic         w_clr_we;
    logic [R-1:0] w_clr_addr;
    logic         w_run;
    logic [R-1:0] w_waddr0, w_waddr1;
    logic [N-1:0] w_wdata0, w_wdata1;
    logic         w_lane_ok0, w_lane_ok1;
    logic         w_mem_we0;
    logic [R-1:0] w_mem_addr0;
    logic [N-1:0] w_mem_data0;

    reg_file_clr_fsm #(.R(R)) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (ready)
    );

    assign w_run    = ready & ~rst;
    assign w_waddr0 = waddr[0 +: R];
    assign w_waddr1 = waddr[R +: R];
    assign w_wdata0 = wdata[0 +: N];
    assign w_wdata1 = wdata[N +: N];

    // A lane write is effective only in RUN and never to a hardwired zero.
    assign w_lane_ok0 = w_run & we[0] & ~((ZERO_REG != 0) && (w_waddr0 == '0));
    assign w_lane_ok1 = w_run & we[1] & ~((ZERO_REG != 0) && (w_waddr1 == '0));

    // The sweep shares lane 0's array port; the two never coexist.
    assign w_mem_we0   = w_clr_we | w_lane_ok0;
    assign w_mem_addr0 = w_clr_we ? w_clr_addr : w_waddr0;
    assign w_mem_data0 = w_clr_we ? '0 : w_wdata0;

    // Lane 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (w_mem_we0)
            r_mem[w_mem_addr0] <= w_mem_data0;
        if (w_lane_ok1)
            r_mem[w_waddr1] <= w_wdata1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_wr_conflict <= 1'b0;
        else
            r_wr_conflict <= w_lane_ok0 & w_lane_ok1 & (w_waddr0 == w_waddr1);
    end

    assign wr_conflict = r_wr_conflict;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_rd
            logic [R-1:0] w_raddr;
            logic         w_hit0, w_hit1;
            logic [N-1:0] r_rd_data;

            assign w_raddr = rd_addr[gi*R +: R];
            assign w_hit0  = w_lane_ok0 && (w_waddr0 == w_raddr);
            assign w_hit1  = w_lane_ok1 && (w_waddr1 == w_raddr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (w_run && rd_en[gi]) begin
                    if ((ZERO_REG != 0) && (w_raddr == '0))
                        r_rd_data <= '0;
                    else if (w_hit0 || w_hit1)
                        r_rd_data <= lane_win(w_hit0, w_hit1) ? w_wdata1 : w_wdata0;
                    else
                        r_rd_data <= r_mem[w_raddr];
                end
            end

            assign rd_data[gi*N +: N] = r_rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    localparam int N  = 32;
    localparam int R  = 4;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready;
    logic [1:0]      we = '0;
    logic [2*R-1:0]  waddr = '0;
    logic [2*N-1:0]  wdata = '0;
    logic [NR-1:0]   rd_en = '0;
    logic [NR*R-1:0] rd_addr = '0;
    logic [NR*N-1:0] rd_data;
    logic            wr_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain array of entries plus last value seen per port.
    logic [N-1:0] m_mem [16];
    logic [N-1:0] m_rd  [NR];

    reg_file_mp #(.N(N), .R(R), .NR(NR), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Releases reset and hammers writes/reads during the sweep; all must be
    // ignored, and ready must rise on exactly the 16th edge.
    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        rst = 1'b0;
        we = 2'b11;
        rd_en = 2'b11;
        while (ready !== 1'b1 && cnt < 40) begin
            waddr   = 8'($urandom);
            wdata   = {$urandom, $urandom};
            rd_addr = 8'($urandom);
            tick();
            cnt++;
            chk({tag, "_sweep_rd0"}, rd_data[31:0], 32'h0);
            chk({tag, "_sweep_rd1"}, rd_data[63:32], 32'h0);
            chk({tag, "_sweep_conf"}, {31'b0, wr_conflict}, 32'h0);
        end
        we = 2'b00;
        rd_en = 2'b00;
        chk({tag, "_sweep_cycles"}, 32'(cnt), 32'd16);
        $display("[TB] %s: ready after %0d cycles", tag, cnt);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_en   = 2'b11;
            rd_addr = {4'(2*i+1), 4'(2*i)};
            tick();
            chk({tag, "_rd_even"}, rd_data[31:0], 32'h0);
            chk({tag, "_rd_odd"}, rd_data[63:32], 32'h0);
            $display("[TB] %s read entries %0d,%0d -> %h %h", tag, 2*i, 2*i+1,
                     rd_data[31:0], rd_data[63:32]);
        end
        rd_en = 2'b00;
    endtask

    initial begin
        // 1: reset state, sweep length, all entries clear
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
        chk("reset_conf", {31'b0, wr_conflict}, 32'h0);
        wait_ready("t1");
        read_all_zero("t1");

        // Fill every entry with nonzero data so the next clear is observable
        for (int i = 0; i < 8; i++) begin
            we    = 2'b11;
            waddr = {4'(2*i+1), 4'(2*i)};
            wdata = {32'hF0F0_0000 | 32'(i), 32'h0F0F_0000 | 32'(i)};
            tick();
        end
        we = 2'b00;

        // 2: reset again, interrupted at sweep cycle 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t2_midsweep_ready", {31'b0, ready}, 32'h0);
        rst = 1'b1;
        tick();
        wait_ready("t2");
        read_all_zero("t2");

        // 3: write-first bypass on port 0, then port 1 reads the stored value
        we = 2'b01; waddr = {4'd0, 4'd9}; wdata = {32'h0, 32'hDEAD_BEEF};
        rd_en = 2'b01; rd_addr = {4'd0, 4'd9};
        tick();
        chk("t3_bypass_rd0", rd_data[31:0], 32'hDEAD_BEEF);
        we = 2'b00; rd_en = 2'b10; rd_addr = {4'd9, 4'd0};
        tick();
        chk("t3_stored_rd1", rd_data[63:32], 32'hDEAD_BEEF);
        $display("[TB] t3 rd0=%h rd1=%h", rd_data[31:0], rd_data[63:32]);

        // 4: both lanes to entry 12; lane 1 wins, one-cycle conflict pulse
        we = 2'b11; waddr = {4'd12, 4'd12}; wdata = {32'h2, 32'h1}; rd_en = 2'b00;
        tick();
        chk("t4_conf_pulse", {31'b0, wr_conflict}, 32'h1);
        we = 2'b00;
        tick();
        chk("t4_conf_clear", {31'b0, wr_conflict}, 32'h0);
        rd_en = 2'b01; rd_addr = {4'd0, 4'd12};
        tick();
        chk("t4_lane1_wins", rd_data[31:0], 32'h2);
        $display("[TB] t4 entry12=%h", rd_data[31:0]);

        // 5: hardwired zero entry
        we = 2'b01; waddr = {4'd0, 4'd0}; wdata = {32'h0, 32'h55};
        rd_en = 2'b01; rd_addr = {4'd0, 4'd0};
        tick();
        chk("t5_zero_bypass", rd_data[31:0], 32'h0);
        chk("t5_zero_noconf", {31'b0, wr_conflict}, 32'h0);
        we = 2'b11; wdata = {32'h66, 32'h77}; rd_en = 2'b00;
        tick();
        chk("t5_zero_dual_noconf", {31'b0, wr_conflict}, 32'h0);
        we = 2'b00; rd_en = 2'b01; rd_addr = {4'd0, 4'd12};
        tick();
        rd_addr = {4'd0, 4'd0};
        tick();
        chk("t5_zero_later", rd_data[31:0], 32'h0);
        $display("[TB] t5 entry0=%h", rd_data[31:0]);

        // 6: rd_en=0 holds data while address and entry change
        we = 2'b01; waddr = {4'd0, 4'd3}; wdata = {32'h0, 32'hA5}; rd_en = 2'b00;
        tick();
        we = 2'b00; rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        tick();
        chk("t6_read_a5", rd_data[31:0], 32'hA5);
        rd_en = 2'b00;
        for (int i = 0; i < 3; i++) begin
            we = 2'b01; waddr = {4'd0, 4'd3}; wdata = {32'h0, 32'h100 + 32'(i)};
            rd_addr = {4'd0, 4'(5 + i)};
            tick();
            chk("t6_hold", rd_data[31:0], 32'hA5);
            $display("[TB] t6 hold cycle %0d rd0=%h", i, rd_data[31:0]);
        end
        we = 2'b00;

        // Randomized traffic against the model, starting from a fresh sweep
        rst = 1'b1;
        tick();
        wait_ready("rnd");
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        for (int k = 0; k < NR; k++) m_rd[k] = '0;
        for (int c = 0; c < 250; c++) begin
            logic [3:0]  a0, a1, r0, r1;
            logic [31:0] d0, d1;
            logic        exp_conf;
            a0 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            r0 = ($urandom_range(0, 1) != 0) ? a0 : 4'($urandom);
            r1 = ($urandom_range(0, 1) != 0) ? a1 : 4'($urandom);
            d0 = $urandom;
            d1 = $urandom;
            we = 2'($urandom);
            rd_en = 2'($urandom);
            waddr = {a1, a0};
            wdata = {d1, d0};
            rd_addr = {r1, r0};
            // Writes land in lane order, entry 0 never changes, reads see the result.
            if (we[0] && a0 != 0) m_mem[a0] = d0;
            if (we[1] && a1 != 0) m_mem[a1] = d1;
            exp_conf = we[0] && we[1] && (a0 == a1) && (a0 != 0);
            if (rd_en[0]) m_rd[0] = (r0 == 0) ? 32'h0 : m_mem[r0];
            if (rd_en[1]) m_rd[1] = (r1 == 0) ? 32'h0 : m_mem[r1];
            tick();
            chk("rnd_rd0", rd_data[31:0], m_rd[0]);
            chk("rnd_rd1", rd_data[63:32], m_rd[1]);
            chk("rnd_conf", {31'b0, wr_conflict}, {31'b0, exp_conf});
            $display("[TB] rnd %0d we=%b wa=%h/%h re=%b ra=%h/%h rd=%h/%h conf=%b",
                     c, we, a0, a1, rd_en, r0, r1, rd_data[31:0], rd_data[63:32], wr_conflict);
        end
        we = 2'b00;
        rd_en = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
